// File: rtl/dungv_pkg.sv
// Shared fetch-unit types: FSM encoding, bus widths, reset vector and the buffered entry layout.
package dungv_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 32;
  localparam int ENTRY_W = PC_W + INSTR_W;

  localparam logic [PC_W-1:0] RESET_PC = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer of pc/instruction pairs with a synchronous flush.
// A pushed entry reaches the head the cycle after the push; push and pop may coincide when full.
module fetch_fifo import dungv_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int W     = ENTRY_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [W-1:0]           i_din,
  input  logic                   i_pop,
  output logic [W-1:0]           o_dout,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = i_pop & ~w_empty;
  assign w_push  = i_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is left unreset; the top gates the head with the valid flag.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush && !rst) r_mem[r_wr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd];
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: credit-limited prefetch into fetch_fifo, redirect flush, one-cycle read latency.
// Define INSTR_FETCH_LOAD_EN to add the LOAD state that writes memory through the fetch port.
module instr_fetch import dungv_pkg::*; #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               fetch_en,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc
`ifdef INSTR_FETCH_LOAD_EN
  ,
  input  logic               load_valid,
  input  logic [PC_W-1:0]    load_addr,
  input  logic [INSTR_W-1:0] load_data,
  output logic               load_done,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               mem_wdata_oe
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = CW + 1;

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_rd_pc;
  logic            r_inflight;
  logic            w_load_start;
  logic            w_load_end;
  logic            w_flush;
  logic            w_issue;
  logic            w_push;
  logic            w_pop;
  logic            w_valid;
  logic [CW-1:0]   w_count;
  logic [OW-1:0]   w_occ;
  fetch_entry_t    w_push_entry;
  fetch_entry_t    w_head;

`ifdef INSTR_FETCH_LOAD_EN
  assign w_load_start = (r_state == ST_FETCH) & load_valid & ~redirect_valid;
`else
  assign w_load_start = 1'b0;
`endif

  // Redirect and load entry both discard the buffer and the read returning this cycle.
  assign w_flush = redirect_valid | w_load_start;
  assign w_valid = (w_count != '0);
  assign w_pop   = w_valid & instr_ready & ~w_flush;
  assign w_push  = r_inflight & ~w_flush;

  // A pop this cycle frees a slot, so steady-state streaming issues every cycle.
  assign w_occ   = OW'(w_count) + OW'(r_inflight) - OW'(w_pop);
  assign w_issue = (r_state == ST_FETCH) & ~w_flush & (w_occ < OW'(FIFO_DEPTH));

  always_comb begin
    w_state_nxt = r_state;
    w_load_end  = 1'b0;
    fetch_en    = 1'b1;
    pc          = r_pc;
`ifdef INSTR_FETCH_LOAD_EN
    mem_wdata    = '0;
    mem_wdata_oe = 1'b0;
`endif
    case (r_state)
      ST_IDLE:  w_state_nxt = ST_FETCH;
      ST_FETCH: if (w_load_start) w_state_nxt = ST_LOAD;
`ifdef INSTR_FETCH_LOAD_EN
      ST_LOAD: begin
        pc = load_addr;
        if (load_valid && !rst) begin
          fetch_en     = 1'b0;
          mem_wdata    = load_data;
          mem_wdata_oe = 1'b1;
        end
        if (redirect_valid) begin
          w_state_nxt = ST_FETCH;
        end else if (!load_valid) begin
          w_state_nxt = ST_FETCH;
          w_load_end  = 1'b1;
        end
      end
`endif
      default:  w_state_nxt = ST_IDLE;
    endcase
`ifdef INSTR_FETCH_LOAD_EN
    load_done = w_load_end;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_rd_pc    <= RESET_PC;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      if (w_issue) r_rd_pc <= r_pc;
      if (redirect_valid)  r_pc <= redirect_pc;
      else if (w_load_end) r_pc <= RESET_PC;
      else if (w_issue)    r_pc <= r_pc + PC_W'(1);
    end
  end

  assign w_push_entry = '{pc: r_rd_pc, instr: mem_rdata};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENTRY_W)
  ) u_fetch_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_din   (w_push_entry),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_count (w_count)
  );

  assign instr_valid = w_valid;
  assign instr_data  = w_valid ? w_head.instr : '0;
  assign instr_pc    = w_valid ? w_head.pc    : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: one-cycle-latency memory model plus an in-order scoreboard of pc/data pairs.
module tb_instr_fetch;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic [7:0]  pc;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [7:0]  instr_pc;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
`ifdef INSTR_FETCH_LOAD_EN
  logic        load_valid;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic        load_done;
  logic [31:0] mem_wdata;
  logic        mem_wdata_oe;
`endif

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic [39:0] exp_q   [$];
  logic [39:0] sb_exp;
  logic        in_load;
  int          vectors = 0;
  int          errors  = 0;
  int          n_xfer  = 0;

  instr_fetch #(.FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .pc             (pc),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef INSTR_FETCH_LOAD_EN
    ,
    .load_valid     (load_valid),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .load_done      (load_done),
    .mem_wdata      (mem_wdata),
    .mem_wdata_oe   (mem_wdata_oe)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + i;
    mem[0] <= 32'h11;
    mem[1] <= 32'h22;
    mem[2] <= 32'h33;
    mem[3] <= 32'h44;
  end

  // Synchronous memory: write when fetch_en is low, read data valid the following cycle.
  always @(posedge clk) begin
`ifdef INSTR_FETCH_LOAD_EN
    if (!fetch_en) mem[pc] <= mem_wdata;
`endif
    mem_rdata <= mem[pc];
  end

`ifdef INSTR_FETCH_LOAD_EN
  assign in_load = load_valid;
`else
  assign in_load = 1'b0;
`endif

  // Scoreboard: every accepted instruction must match the next expected pc/data pair.
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready && !redirect_valid && !in_load) begin
      vectors++;
      n_xfer++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got pc=%h data=%h, required no transfer", instr_pc, instr_data);
      end else begin
        sb_exp = exp_q.pop_front();
        if ({instr_pc, instr_data} !== sb_exp) begin
          errors++;
          $display("FAIL sb_order: got pc=%h data=%h, required pc=%h data=%h",
                   instr_pc, instr_data, sb_exp[39:32], sb_exp[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_restart(input logic [7:0] start, input int n);
    logic [7:0] a;
    exp_q.delete();
    n_xfer = 0;
    a = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({a, ref_mem[a]});
      a = a + 8'd1;
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
`ifdef INSTR_FETCH_LOAD_EN
    load_valid = 1'b0;
`endif
    tick();
    tick();
    exp_q.delete();
    n_xfer = 0;
    rst    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    @(negedge clk);
    vectors++; if (pc !== 8'h00)        begin errors++; $display("FAIL reset_pc: got %h, required 00", pc); end
    vectors++; if (fetch_en !== 1'b1)   begin errors++; $display("FAIL reset_fetch_en: got %b, required 1", fetch_en); end
    vectors++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", instr_valid); end
    vectors++; if (instr_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h, required 0", instr_data); end
    vectors++; if (instr_pc !== 8'h00)  begin errors++; $display("FAIL reset_instr_pc: got %h, required 00", instr_pc); end
    tick();
  endtask

  task automatic test_stream();
    int first;
    int nvalid;
    instr_ready = 1'b1;
    do_reset();
    sb_restart(8'h00, 16);
    first  = -1;
    nvalid = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (instr_valid && first < 0) first = c;
      if (c >= 3 && c <= 6 && instr_valid) nvalid++;
    end
    vectors++; if (first != 3)   begin errors++; $display("FAIL stream_first_valid: got cycle %0d, required 3", first); end
    vectors++; if (nvalid != 4)  begin errors++; $display("FAIL stream_back_to_back: got %0d valid cycles, required 4", nvalid); end
    vectors++; if (n_xfer < 8)   begin errors++; $display("FAIL stream_count: got %0d transfers, required >= 8", n_xfer); end
    tick();
  endtask

  task automatic test_stall();
    int bad;
    instr_ready = 1'b0;
    do_reset();
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (fetch_en !== 1'b1) bad++;
      if (c < 9) tick();
    end
    vectors++; if (pc !== 8'(DEPTH))      begin errors++; $display("FAIL stall_pc: got %h, required %h", pc, 8'(DEPTH)); end
    vectors++; if (bad != 0)              begin errors++; $display("FAIL stall_fetch_en: got %0d low cycles, required 0", bad); end
    vectors++; if (instr_valid !== 1'b1)  begin errors++; $display("FAIL stall_valid: got %b, required 1", instr_valid); end
    tick();
    sb_restart(8'h00, 20);
    instr_ready = 1'b1;
    for (int c = 0; c < 12; c++) tick();
    vectors++; if (n_xfer < 10) begin errors++; $display("FAIL stall_release: got %0d transfers, required >= 10", n_xfer); end
  endtask

  task automatic test_redirect();
    instr_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 8; c++) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 8'h40;
    sb_restart(8'h40, 16);
    tick();
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    @(negedge clk);
    vectors++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redirect_full_flush: got valid %b, required 0", instr_valid); end
    for (int c = 0; c < 8; c++) tick();
    vectors++; if (n_xfer < 4) begin errors++; $display("FAIL redirect_full_count: got %0d transfers, required >= 4", n_xfer); end
    // Mid-stream redirect, so a live read return must be discarded.
    instr_ready    = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFF;
    sb_restart(8'hFF, 16);
    tick();
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    @(negedge clk);
    vectors++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redirect_wrap_flush: got valid %b, required 0", instr_valid); end
    for (int c = 0; c < 8; c++) tick();
    vectors++; if (n_xfer < 4) begin errors++; $display("FAIL redirect_wrap_count: got %0d transfers, required >= 4", n_xfer); end
  endtask

  task automatic test_reset_mid();
    instr_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 6; c++) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    vectors++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b, required 0", instr_valid); end
    vectors++; if (instr_data !== 32'h0) begin errors++; $display("FAIL midrst_data: got %h, required 0", instr_data); end
    tick();
    sb_restart(8'h00, 16);
    rst         = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    vectors++; if (pc !== 8'h00) begin errors++; $display("FAIL midrst_idle_pc: got %h, required 00", pc); end
    tick();
    @(negedge clk);
    vectors++; if (pc !== 8'h00) begin errors++; $display("FAIL midrst_first_read: got %h, required 00", pc); end
    for (int c = 0; c < 10; c++) tick();
    vectors++; if (n_xfer < 6) begin errors++; $display("FAIL midrst_count: got %0d transfers, required >= 6", n_xfer); end
  endtask

`ifdef INSTR_FETCH_LOAD_EN
  task automatic test_load();
    instr_ready = 1'b1;
    do_reset();
    sb_restart(8'h00, 16);
    for (int c = 0; c < 6; c++) tick();
    instr_ready = 1'b0;
    load_valid  = 1'b1;
    load_addr   = 8'h05;
    load_data   = 32'hA5;
    tick();
    for (int i = 0; i < 3; i++) begin
      load_addr = 8'h05 + 8'(i);
      @(negedge clk);
      vectors++; if (fetch_en !== 1'b0)     begin errors++; $display("FAIL load_fetch_en: got %b, required 0", fetch_en); end
      vectors++; if (pc !== load_addr)      begin errors++; $display("FAIL load_pc: got %h, required %h", pc, load_addr); end
      vectors++; if (mem_wdata_oe !== 1'b1) begin errors++; $display("FAIL load_oe: got %b, required 1", mem_wdata_oe); end
      vectors++; if (mem_wdata !== 32'hA5)  begin errors++; $display("FAIL load_wdata: got %h, required a5", mem_wdata); end
      tick();
    end
    load_valid = 1'b0;
    @(negedge clk);
    vectors++; if (load_done !== 1'b1) begin errors++; $display("FAIL load_done_pulse: got %b, required 1", load_done); end
    vectors++; if (fetch_en !== 1'b1)  begin errors++; $display("FAIL load_end_fetch_en: got %b, required 1", fetch_en); end
    tick();
    @(negedge clk);
    vectors++; if (load_done !== 1'b0) begin errors++; $display("FAIL load_done_width: got %b, required 0", load_done); end
    vectors++; if (pc !== 8'h00)       begin errors++; $display("FAIL load_restart_pc: got %h, required 00", pc); end
    for (int a = 5; a <= 7; a++) ref_mem[a] = 32'hA5;
    sb_restart(8'h00, 16);
    tick();
    instr_ready = 1'b1;
    for (int c = 0; c < 14; c++) tick();
    vectors++; if (n_xfer < 9) begin errors++; $display("FAIL load_readback_count: got %0d transfers, required >= 9", n_xfer); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h1000_0000 + i;
    ref_mem[0] = 32'h11;
    ref_mem[1] = 32'h22;
    ref_mem[2] = 32'h33;
    ref_mem[3] = 32'h44;
    rst            = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
`ifdef INSTR_FETCH_LOAD_EN
    load_valid = 1'b0;
    load_addr  = 8'h00;
    load_data  = 32'h0;
`endif
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_reset_mid();
`ifdef INSTR_FETCH_LOAD_EN
    test_load();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
